// File: rtl/stream_fifo_adaptive_pkg.sv
// Shared definitions for the depth-selectable stream buffer.
// Holds the pointer-width helper and the default payload type.
package stream_fifo_adaptive_pkg;

   localparam int unsigned DefaultDataWidth = 32;

   typedef logic [DefaultDataWidth-1:0] payload_t;

   // Pointer/usage width for a buffer of the given depth; never narrower than one bit.
   function automatic int unsigned addr_depth(input int unsigned depth);
      if (depth > 1) begin
         return $clog2(depth);
      end
      return 1;
   endfunction

endpackage

// File: rtl/stream_spill_stage.sv
// Two-slot spill register (A = input slot, B = overflow slot) with synchronous flush.
// Full throughput with ready_i held high; ready_o/valid_o come only from slot flags.
module stream_spill_stage
   import stream_fifo_adaptive_pkg::*;
#(
   parameter type T = payload_t
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  T     data_i,
   input  logic valid_i,
   output logic ready_o,
   output T     data_o,
   output logic valid_o,
   input  logic ready_i
);

   logic a_full_q, a_full_d;
   logic b_full_q, b_full_d;
   T     a_data_q, a_data_d;
   T     b_data_q, b_data_d;
   logic a_fill, a_drain, b_fill, b_drain;

   assign ready_o = !(a_full_q && b_full_q);
   assign valid_o = a_full_q || b_full_q;
   assign data_o  = b_full_q ? b_data_q : a_data_q;

   // Slot transfers: A empties whenever B is free, landing in B only if the consumer stalls.
   always_comb begin
      a_fill   = valid_i && ready_o && !flush_i;
      a_drain  = a_full_q && !b_full_q;
      b_fill   = a_drain && !ready_i;
      b_drain  = b_full_q && ready_i;
      a_full_d = a_full_q;
      b_full_d = b_full_q;
      a_data_d = a_fill ? data_i : a_data_q;
      b_data_d = b_fill ? a_data_q : b_data_q;
      if (a_fill) begin
         a_full_d = 1'b1;
      end else if (a_drain) begin
         a_full_d = 1'b0;
      end
      if (b_fill) begin
         b_full_d = 1'b1;
      end else if (b_drain) begin
         b_full_d = 1'b0;
      end
      if (flush_i) begin
         a_full_d = 1'b0;
         b_full_d = 1'b0;
      end
   end

   // Slot flags and payloads; payload contents are irrelevant while a slot is empty.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_data_q <= '0;
         b_data_q <= '0;
      end else begin
         a_full_q <= a_full_d;
         b_full_q <= b_full_d;
         a_data_q <= a_data_d;
         b_data_q <= b_data_d;
      end
   end

endmodule

// File: rtl/stream_fifo_adaptive.sv
// Depth-selectable valid/ready stream buffer: spill register for Depth==2,
// circular-buffer FIFO for Depth>2. No fall-through; synchronous flush.
// Optional protocol checks are compiled in with STREAM_FIFO_ADAPTIVE_ASSERT_EN.
module stream_fifo_adaptive
   import stream_fifo_adaptive_pkg::*;
#(
   parameter int unsigned  Depth     = 8,
   parameter int unsigned  DataWidth = 32,
   localparam int unsigned AddrDepth = addr_depth(Depth)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 testmode_i,
   output logic [AddrDepth-1:0] usage_o,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i
);

   // Clock-gating bypass has no functional role in this buffer.
   logic unused_testmode;
   assign unused_testmode = testmode_i;

   if (Depth < 2) begin : g_bad_depth
      $fatal(1, "FIFO of depth %0d does not make any sense", Depth);
   end else if (Depth == 2) begin : g_spill
      stream_spill_stage #(
         .T(logic [DataWidth-1:0])
      ) u_spill (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .flush_i(flush_i),
         .data_i (data_i),
         .valid_i(valid_i),
         .ready_o(ready_o),
         .data_o (data_o),
         .valid_o(valid_o),
         .ready_i(ready_i)
      );
      assign usage_o = '0;
   end else begin : g_fifo
      localparam logic [AddrDepth:0]   FullCount = (AddrDepth+1)'(Depth);
      localparam logic [AddrDepth-1:0] LastPtr   = AddrDepth'(Depth - 1);

      logic [AddrDepth-1:0] rd_ptr_q, rd_ptr_d;
      logic [AddrDepth-1:0] wr_ptr_q, wr_ptr_d;
      logic [AddrDepth:0]   count_q, count_d;
      logic [DataWidth-1:0] mem_q [Depth];
      logic                 push, pop;

      assign ready_o = (count_q != FullCount);
      assign valid_o = (count_q != '0);
      assign data_o  = mem_q[rd_ptr_q];
      assign usage_o = count_q[AddrDepth-1:0];

      // Pointer and fill-count update; pointers wrap at Depth-1 so odd depths work too.
      always_comb begin
         push     = valid_i && ready_o && !flush_i;
         pop      = valid_o && ready_i && !flush_i;
         rd_ptr_d = rd_ptr_q;
         wr_ptr_d = wr_ptr_q;
         count_d  = count_q;
         if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
         if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
         end
      end

      // Control state; storage array is left out of reset since its contents are don't-care.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
         end
      end

      // Storage write at the current write pointer on an accepted push.
      always_ff @(posedge clk_i) begin
         if (push) begin
            mem_q[wr_ptr_q] <= data_i;
         end
      end
   end

`ifdef STREAM_FIFO_ADAPTIVE_ASSERT_EN
   CheckFullPush: assert property (@(posedge clk_i) disable iff (!rst_ni) !(valid_i && !ready_o))
      else $error("CheckFullPush: push attempted while buffer full");
   CheckEmptyPop: assert property (@(posedge clk_i) disable iff (!rst_ni) !(ready_i && !valid_o))
      else $error("CheckEmptyPop: pop attempted while buffer empty");
`else
   // Protocol checks are not compiled in this build.
`endif

endmodule

// File: tb/tb_stream_fifo_adaptive.sv
// Testbench for stream_fifo_adaptive: three instances (Depth 2, 5, 8) share one
// stimulus stream; each is compared every cycle against a queue model.
module tb_stream_fifo_adaptive;

   localparam int NumDut = 3;
   localparam int DepthTab [NumDut] = '{2, 5, 8};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        testmode;
   logic        valid;
   logic        ready;
   logic [31:0] data;

   logic        ready2, valid2, ready5, valid5, ready8, valid8;
   logic [31:0] data2, data5, data8;
   logic        usage2;
   logic [2:0]  usage5, usage8;

   logic        rdy [NumDut];
   logic        vld [NumDut];
   logic [31:0] dat [NumDut];
   int unsigned usg [NumDut];

   int checks = 0;
   int errors = 0;

   logic [31:0] mq [NumDut][$];

   always #5 clk = ~clk;

   stream_fifo_adaptive #(.Depth(2), .DataWidth(32)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
      .usage_o(usage2), .data_i(data), .valid_i(valid), .ready_o(ready2),
      .data_o(data2), .valid_o(valid2), .ready_i(ready)
   );

   stream_fifo_adaptive #(.Depth(5), .DataWidth(32)) dut5 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
      .usage_o(usage5), .data_i(data), .valid_i(valid), .ready_o(ready5),
      .data_o(data5), .valid_o(valid5), .ready_i(ready)
   );

   stream_fifo_adaptive #(.Depth(8), .DataWidth(32)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
      .usage_o(usage8), .data_i(data), .valid_i(valid), .ready_o(ready8),
      .data_o(data8), .valid_o(valid8), .ready_i(ready)
   );

   assign rdy[0] = ready2;
   assign rdy[1] = ready5;
   assign rdy[2] = ready8;
   assign vld[0] = valid2;
   assign vld[1] = valid5;
   assign vld[2] = valid8;
   assign dat[0] = data2;
   assign dat[1] = data5;
   assign dat[2] = data8;
   assign usg[0] = 32'(usage2);
   assign usg[1] = 32'(usage5);
   assign usg[2] = 32'(usage8);

   task automatic check_output(input string name, input longint unsigned act,
                               input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after a falling edge; return just after the next falling edge.
   task automatic apply_stimulus(input logic v, input logic r, input logic [31:0] d,
                                 input logic f);
      valid = v;
      ready = r;
      data  = d;
      flush = f;
      @(negedge clk);
      #1;
   endtask

   // Buffer model: a plain queue per depth. Push accepted while not full, pop while
   // non-empty, flush clears everything and drops the same-cycle push.
   always @(posedge clk or negedge rst_n) begin
      bit do_push, do_pop;
      if (!rst_n) begin
         for (int i = 0; i < NumDut; i++) mq[i].delete();
      end else begin
         for (int i = 0; i < NumDut; i++) begin
            if (flush) begin
               mq[i].delete();
            end else begin
               do_push = valid && (mq[i].size() < DepthTab[i]);
               do_pop  = ready && (mq[i].size() > 0);
               if (do_pop) void'(mq[i].pop_front());
               if (do_push) mq[i].push_back(data);
            end
         end
      end
   end

   // Every-cycle comparison of all instances against the model.
   always @(negedge clk) begin
      int sz;
      int unsigned exp_usage;
      for (int i = 0; i < NumDut; i++) begin
         sz = mq[i].size();
         exp_usage = (DepthTab[i] == 2) ? 0 : (sz % (1 << $clog2(DepthTab[i])));
         check_output($sformatf("ready_o d%0d", DepthTab[i]), rdy[i], sz != DepthTab[i]);
         check_output($sformatf("valid_o d%0d", DepthTab[i]), vld[i], sz != 0);
         if (sz != 0) check_output($sformatf("data_o d%0d", DepthTab[i]), dat[i], mq[i][0]);
         check_output($sformatf("usage_o d%0d", DepthTab[i]), usg[i], exp_usage);
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      testmode = 1'b0;
      flush    = 1'b0;
      valid    = 1'b0;
      ready    = 1'b0;
      data     = '0;
      @(negedge clk);
      #1;
      check_output("reset valid_o d8", valid8, 0);
      check_output("reset ready_o d8", ready8, 1);
      check_output("reset usage_o d8", usage8, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      #1;

      $display("[TB] depth 8 fill and drain");
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(1'b1, 1'b0, 32'h11 + 32'(k), 1'b0);
         check_output("fill usage_o d8", usage8, (k + 1) % 8);
         check_output("fill ready_o d8", ready8, k < 7);
      end
      for (int k = 0; k < 8; k++) begin
         check_output("drain valid_o d8", valid8, 1);
         check_output("drain data_o d8", data8, 32'h11 + 32'(k));
         apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0);
      end
      check_output("drained valid_o d8", valid8, 0);

      $display("[TB] depth 2 stall and pop");
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 32'hA, 1'b0);
      apply_stimulus(1'b1, 1'b0, 32'hB, 1'b0);
      check_output("stall ready_o d2", ready2, 0);
      check_output("stall data_o d2", data2, 32'hA);
      apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0);
      check_output("pop data_o d2", data2, 32'hB);
      check_output("pop ready_o d2", ready2, 1);

      $display("[TB] depth 2 continuous streaming");
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         apply_stimulus(1'b1, 1'b1, 32'(k), 1'b0);
         check_output("stream ready_o d2", ready2, 1);
         check_output("stream valid_o d2", valid2, 1);
         check_output("stream data_o d2", data2, 32'(k));
      end

      $display("[TB] depth 5 wrap with toggling ready");
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         apply_stimulus(1'b1, logic'(k % 2), 32'h60 + 32'(k), 1'b0);
      end
      for (int k = 0; k < 12; k++) begin
         apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0);
      end
      check_output("wrap drained valid_o d5", valid5, 0);

      $display("[TB] flush with concurrent push");
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(1'b1, 1'b0, 32'h31 + 32'(k), 1'b0);
      end
      check_output("pre-flush usage_o d8", usage8, 3);
      apply_stimulus(1'b1, 1'b0, 32'h55, 1'b1);
      check_output("flush valid_o d2", valid2, 0);
      check_output("flush valid_o d5", valid5, 0);
      check_output("flush valid_o d8", valid8, 0);
      check_output("flush usage_o d8", usage8, 0);
      check_output("flush ready_o d2", ready2, 1);
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0);
         check_output("post-flush valid_o d8", valid8, 0);
      end

      $display("[TB] random traffic");
      for (int c = 0; c < 300; c++) begin
         apply_stimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
                        32'($urandom), logic'($urandom_range(0, 31) == 0));
      end
      for (int c = 0; c < 6; c++) begin
         apply_stimulus(1'b1, 1'b0, 32'($urandom), 1'b0);
      end

      $display("[TB] mid-stream reset");
      check_output("pre-reset valid_o d8", valid8, 1);
      rst_n = 1'b0;
      #1;
      check_output("async reset valid_o d2", valid2, 0);
      check_output("async reset valid_o d8", valid8, 0);
      check_output("async reset ready_o d2", ready2, 1);
      check_output("async reset ready_o d5", ready5, 1);
      check_output("async reset usage_o d5", usage5, 0);
      valid = 1'b0;
      ready = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      for (int c = 0; c < 1500; c++) begin
         apply_stimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                        32'($urandom), logic'($urandom_range(0, 47) == 0));
      end
      for (int c = 0; c < 10; c++) begin
         apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0);
      end
      check_output("final valid_o d8", valid8, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
